// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - MEM-stage controller that stalls the pipeline across a req/ack data-memory transaction
module mem_stall_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              EX_MEM_MemRead_i,
  input  logic              EX_MEM_MemWrite_i,
  input  logic [ADDR_W-1:0] EX_MEM_Addr_i,
  input  logic [DATA_W-1:0] EX_MEM_WData_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              MemStall_o,
  output logic [DATA_W-1:0] RData_o,
  output logic              Err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter only needs to reach TIMEOUT-1; a zero TIMEOUT disables the abort path.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_access;
  logic w_misaligned;
  logic w_take;
  logic w_timeout;

  assign w_access     = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
  assign w_misaligned = |EX_MEM_Addr_i[1:0];
  assign w_take       = (r_state == S_IDLE) & w_access & ~w_misaligned;
  assign w_timeout    = TIMEOUT_EN & (r_cnt == CNT_LAST);

  // Stall must rise in the same cycle the access is seen, so it is combinational;
  // gating with reset keeps it low while the pipeline is being reset.
  assign MemStall_o = rst_i & (w_take | (r_state == S_REQ));

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign RData_o     = r_rdata;
  assign Err_o       = r_err;

  // Transaction FSM: latch the access, hold the request until ack or timeout, then one DONE cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_misaligned) begin
              r_err <= 1'b1;
            end else begin
              r_addr  <= EX_MEM_Addr_i;
              r_wdata <= EX_MEM_WData_i;
              // A simultaneous read and write request is treated as a write.
              r_we    <= EX_MEM_MemWrite_i;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            if (!r_we) begin
              r_rdata <= mem_rdata_i;
            end
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // EX/MEM still holds the finished instruction here; ignore it to avoid a re-issue.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
